// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: round-robin grant onto one slave bus, SETUP/ACCESS
// sequencing, loser stalled through its pready, optional ACCESS-phase timeout.
module apb_arbiter #(
  parameter int PADDR_WL       = 8,
  parameter int PDATA_WL       = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [PADDR_WL-1:0] m0_paddr,
  input  logic [PDATA_WL-1:0] m0_pwdata,
  output logic [PDATA_WL-1:0] m0_prdata,
  output logic                m0_pready,
  output logic                m0_pslverr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [PADDR_WL-1:0] m1_paddr,
  input  logic [PDATA_WL-1:0] m1_pwdata,
  output logic [PDATA_WL-1:0] m1_prdata,
  output logic                m1_pready,
  output logic                m1_pslverr,
  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [PADDR_WL-1:0] s_paddr,
  output logic [PDATA_WL-1:0] s_pwdata,
  input  logic [PDATA_WL-1:0] s_prdata,
  input  logic                s_pready,
  input  logic                s_pslverr
);

  localparam int                CNT_WL   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WL-1:0] CNT_LAST = CNT_WL'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              grant, grant_next;
  logic              last_grant, last_grant_next;
  logic [CNT_WL-1:0] cnt, cnt_next;
  logic              timeout;
  logic              done;

  // The masters' penable only marks their own access phase; the arbiter
  // re-generates penable for the slave from its own state.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign timeout = TO_EN && (state == ACCESS) && (cnt == CNT_LAST);
  assign done    = (state == ACCESS) && (s_pready || timeout);

  // NOTE: every next-state variable gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    cnt_next        = cnt;
    case (state)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          grant_next = (m0_psel && m1_psel) ? ~last_grant : m1_psel;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end else if (cnt != '1) begin
          cnt_next = cnt + CNT_WL'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      cnt        <= cnt_next;
    end
  end

  always_comb begin
    s_psel    = (state != IDLE);
    s_penable = (state == ACCESS);
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    if (s_psel) begin
      s_pwrite = grant ? m1_pwrite : m0_pwrite;
      s_paddr  = grant ? m1_paddr  : m0_paddr;
      s_pwdata = grant ? m1_pwdata : m0_pwdata;
    end
  end

  always_comb begin
    m0_pready  = done && !grant;
    m1_pready  = done && grant;
    m0_pslverr = m0_pready && (s_pslverr || timeout);
    m1_pslverr = m1_pready && (s_pslverr || timeout);
    m0_prdata  = m0_pready ? s_prdata : '0;
    m1_prdata  = m1_pready ? s_prdata : '0;
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: three instances (timeout 16, 4, disabled) share one
// set of master/slave stimulus; directed tables, corner sequences, random run.
module tb_apb_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NDUT = 3;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          m0_psel, m0_penable, m0_pwrite;
  logic [AW-1:0] m0_paddr;
  logic [DW-1:0] m0_pwdata;
  logic          m1_psel, m1_penable, m1_pwrite;
  logic [AW-1:0] m1_paddr;
  logic [DW-1:0] m1_pwdata;
  logic [DW-1:0] s_prdata;
  logic          s_pready, s_pslverr;

  logic          d_s_psel    [NDUT];
  logic          d_s_penable [NDUT];
  logic          d_s_pwrite  [NDUT];
  logic [AW-1:0] d_s_paddr   [NDUT];
  logic [DW-1:0] d_s_pwdata  [NDUT];
  logic [DW-1:0] d_m0_prdata [NDUT];
  logic          d_m0_pready [NDUT];
  logic          d_m0_pslverr[NDUT];
  logic [DW-1:0] d_m1_prdata [NDUT];
  logic          d_m1_pready [NDUT];
  logic          d_m1_pslverr[NDUT];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int TC = (g == 0) ? 16 : ((g == 1) ? 4 : 0);
    apb_arbiter #(.PADDR_WL(AW), .PDATA_WL(DW), .TIMEOUT_CYCLES(TC)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .m0_psel   (m0_psel),
      .m0_penable(m0_penable),
      .m0_pwrite (m0_pwrite),
      .m0_paddr  (m0_paddr),
      .m0_pwdata (m0_pwdata),
      .m0_prdata (d_m0_prdata[g]),
      .m0_pready (d_m0_pready[g]),
      .m0_pslverr(d_m0_pslverr[g]),
      .m1_psel   (m1_psel),
      .m1_penable(m1_penable),
      .m1_pwrite (m1_pwrite),
      .m1_paddr  (m1_paddr),
      .m1_pwdata (m1_pwdata),
      .m1_prdata (d_m1_prdata[g]),
      .m1_pready (d_m1_pready[g]),
      .m1_pslverr(d_m1_pslverr[g]),
      .s_psel    (d_s_psel[g]),
      .s_penable (d_s_penable[g]),
      .s_pwrite  (d_s_pwrite[g]),
      .s_paddr   (d_s_paddr[g]),
      .s_pwdata  (d_s_pwdata[g]),
      .s_prdata  (s_prdata),
      .s_pready  (s_pready),
      .s_pslverr (s_pslverr)
    );
  end

  function automatic int tc_of(input int g);
    return (g == 0) ? 16 : ((g == 1) ? 4 : 0);
  endfunction

  // Packed view of one instance's outputs: psel, penable, pwrite, paddr,
  // pwdata, then {pready, pslverr, prdata} for m0 and m1.
  function automatic logic [63:0] pack(input logic sp, input logic se, input logic sw,
                                       input logic [7:0] pa, input logic [7:0] pd,
                                       input logic r0, input logic e0, input logic [7:0] d0,
                                       input logic r1, input logic e1, input logic [7:0] d1);
    return {25'b0, sp, se, sw, pa, pd, r0, e0, d0, r1, e1, d1};
  endfunction

  function automatic logic [63:0] outs(input int g);
    return pack(d_s_psel[g], d_s_penable[g], d_s_pwrite[g], d_s_paddr[g], d_s_pwdata[g],
                d_m0_pready[g], d_m0_pslverr[g], d_m0_prdata[g],
                d_m1_pready[g], d_m1_pslverr[g], d_m1_prdata[g]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
    s_prdata = '0; s_pready = 0; s_pslverr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          m0_psel, m0_pwrite;
    logic [7:0]    m0_paddr, m0_pwdata;
    logic          m1_psel, m1_pwrite;
    logic [7:0]    m1_paddr, m1_pwdata;
    logic [7:0]    s_prdata;
    logic          s_pready, s_pslverr;
    logic [63:0]   exp;
  } vec_t;

  function automatic vec_t mk(input logic p0, input logic w0, input logic [7:0] a0, input logic [7:0] wd0,
                              input logic p1, input logic w1, input logic [7:0] a1, input logic [7:0] wd1,
                              input logic [7:0] rd, input logic rdy, input logic err,
                              input logic [63:0] exp);
    vec_t v;
    v.m0_psel = p0; v.m0_pwrite = w0; v.m0_paddr = a0; v.m0_pwdata = wd0;
    v.m1_psel = p1; v.m1_pwrite = w1; v.m1_paddr = a1; v.m1_pwdata = wd1;
    v.s_prdata = rd; v.s_pready = rdy; v.s_pslverr = err; v.exp = exp;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 setup, 2+n the n-th (0-based) access cycle.
  int phase [NDUT];
  bit owner [NDUT];
  bit last  [NDUT];

  task automatic model_reset();
    for (int g = 0; g < NDUT; g++) begin
      phase[g] = 0; owner[g] = 0; last[g] = 1;
    end
  endtask

  function automatic logic [63:0] model_out(input int g);
    bit sel, acc, to, dn, r0, r1;
    logic [7:0] pa, pd;
    bit pw;
    sel = (phase[g] != 0);
    acc = (phase[g] >= 2);
    to  = acc && (tc_of(g) != 0) && (phase[g] - 2 == tc_of(g) - 1);
    dn  = acc && (s_pready || to);
    r0  = dn && !owner[g];
    r1  = dn && owner[g];
    pa  = !sel ? 8'h00 : (owner[g] ? m1_paddr  : m0_paddr);
    pd  = !sel ? 8'h00 : (owner[g] ? m1_pwdata : m0_pwdata);
    pw  = sel && (owner[g] ? m1_pwrite : m0_pwrite);
    return pack(sel, acc, pw, pa, pd,
                r0, r0 && (s_pslverr || to), r0 ? s_prdata : 8'h00,
                r1, r1 && (s_pslverr || to), r1 ? s_prdata : 8'h00);
  endfunction

  task automatic model_step(input int g);
    bit to, dn;
    to = (phase[g] >= 2) && (tc_of(g) != 0) && (phase[g] - 2 == tc_of(g) - 1);
    dn = (phase[g] >= 2) && (s_pready || to);
    if (phase[g] == 0) begin
      if (m0_psel || m1_psel) begin
        owner[g] = (m0_psel && m1_psel) ? !last[g] : m1_psel;
        phase[g] = 1;
      end
    end else if (dn) begin
      last[g]  = owner[g];
      phase[g] = 0;
    end else begin
      phase[g] = phase[g] + 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   got[$];
    int   last_cyc;
    int   acc_cnt;

    tbl[0]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 8'h3C,1,0, pack(0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[1]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 8'h3C,1,0, pack(1,0,0,8'h01,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[2]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 8'h3C,1,0, pack(1,1,0,8'h01,8'h00, 1,0,8'h3C, 0,0,8'h00));
    tbl[3]  = mk(0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 8'hC3,1,1, pack(0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[4]  = mk(0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 8'hC3,1,1, pack(1,0,0,8'h02,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[5]  = mk(0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 8'hC3,1,1, pack(1,1,0,8'h02,8'h00, 0,0,8'h00, 1,1,8'hC3));
    tbl[6]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'hC3,1,0, pack(0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[7]  = mk(1,1,8'h12,8'hA5, 0,0,8'h00,8'h00, 8'h00,1,0, pack(0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0,8'h00));
    tbl[8]  = mk(1,1,8'h12,8'hA5, 0,0,8'h00,8'h00, 8'h00,1,0, pack(1,0,1,8'h12,8'hA5, 0,0,8'h00, 0,0,8'h00));
    tbl[9]  = mk(1,1,8'h12,8'hA5, 0,0,8'h00,8'h00, 8'h00,1,0, pack(1,1,1,8'h12,8'hA5, 1,0,8'h00, 0,0,8'h00));
    tbl[10] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,1,0, pack(0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0,8'h00));

    do_reset();
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("reset_outs_dut%0d", g), outs(g), 64'h0);

    // Simultaneous reads after reset, then a single zero-wait write from m0.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      m0_psel = tbl[i].m0_psel; m0_pwrite = tbl[i].m0_pwrite;
      m0_paddr = tbl[i].m0_paddr; m0_pwdata = tbl[i].m0_pwdata;
      m1_psel = tbl[i].m1_psel; m1_pwrite = tbl[i].m1_pwrite;
      m1_paddr = tbl[i].m1_paddr; m1_pwdata = tbl[i].m1_pwdata;
      s_prdata = tbl[i].s_prdata; s_pready = tbl[i].s_pready; s_pslverr = tbl[i].s_pslverr;
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) check($sformatf("tbl%0d_dut%0d", i, g), outs(g), tbl[i].exp);
    end

    // Round robin: both masters hold psel across six transfers.
    do_reset();
    @(posedge clk); #1;
    m0_psel = 1; m0_paddr = 8'hA0; m1_psel = 1; m1_paddr = 8'hB0; s_pready = 1;
    last_cyc = -1;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      if (d_m0_pready[0]) got.push_back(0);
      if (d_m1_pready[0]) got.push_back(1);
      last_cyc = c;
      @(posedge clk); #1;
    end
    check("rr_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) check($sformatf("rr_grant%0d", i), got[i], i % 2);
    check("rr_last_cycle", last_cyc, 17);

    // Wait states: three stalled ACCESS cycles, completion on the fourth.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      m1_psel = 1; m1_pwrite = 1; m1_paddr = 8'h5A; m1_pwdata = 8'h77;
      s_pready = (k == 5);
      @(negedge clk);
      if (k >= 2 && k < 5) begin
        check($sformatf("wait_pready_k%0d", k), d_m1_pready[0], 0);
        check($sformatf("wait_paddr_k%0d", k), d_s_paddr[0], 8'h5A);
      end
      if (k == 5) begin
        check("wait_done", {d_m1_pready[0], d_m1_pslverr[0], d_s_paddr[0]}, {2'b10, 8'h5A});
      end
    end

    // Timeout on the TIMEOUT_CYCLES=4 instance; disabled instance stays in ACCESS.
    do_reset();
    acc_cnt = 0;
    for (int k = 0; k < 102; k++) begin
      @(posedge clk); #1;
      m0_psel = (k < 6); m0_paddr = 8'h33; s_prdata = 8'h99; s_pready = 0;
      @(negedge clk);
      if (k >= 2 && k < 5) check($sformatf("to4_stall_k%0d", k), d_m0_pready[1], 0);
      if (k == 5) check("to4_done", {d_m0_pready[1], d_m0_pslverr[1], d_m0_prdata[1]}, {2'b11, 8'h99});
      if (k == 6) check("to4_idle", d_s_psel[1], 0);
      if (k >= 2 && d_s_penable[2] && !d_m0_pready[2]) acc_cnt++;
    end
    check("to0_access_cycles", acc_cnt, 100);

    // Reset mid-ACCESS, then m0 wins the first tie.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      m0_psel = 1; m0_paddr = 8'h44;
      @(negedge clk);
    end
    check("rst_pre_access", d_s_penable[0], 1);
    #1 s_pready = 1; reset_b = 0;
    #1;
    for (int g = 0; g < NDUT; g++) check($sformatf("rst_async_dut%0d", g), outs(g), 64'h0);
    @(posedge clk); #1 reset_b = 1;
    m1_psel = 1; m1_paddr = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) check("rst_tie_setup_paddr", d_s_paddr[0], 8'h44);
      if (k == 2) check("rst_tie_m0_pready", {d_m0_pready[0], d_m1_pready[0]}, 2'b10);
      @(posedge clk); #1;
    end

    // Randomized run against the model on all three instances.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      m0_psel = 1'($urandom_range(0, 1)); m0_pwrite = 1'($urandom());
      m0_paddr = 8'($urandom()); m0_pwdata = 8'($urandom());
      m1_psel = 1'($urandom_range(0, 1)); m1_pwrite = 1'($urandom());
      m1_paddr = 8'($urandom()); m1_pwdata = 8'($urandom());
      s_prdata = 8'($urandom()); s_pslverr = ($urandom_range(0, 3) == 0);
      if (((c / 500) % 2) == 1) s_pready = ($urandom_range(0, 7) == 0);
      else                      s_pready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("rand_c%0d_dut%0d", c, g), outs(g), model_out(g));
        model_step(g);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-master APB arbiter that shares one APB register bus between the I2C slave bridge and a second bus master (scan/debug controller). It sequences every slave transfer through SETUP and ACCESS phases, grants the bus round-robin, stalls the losing master through its `pready`, and terminates hung slave transfers with a timeout error. It sits between the masters' APB ports and the register file.

## Interface

Parameters:
- `PADDR_WL`, 8: APB address width.
- `PDATA_WL`, 8: APB data width.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before forced error completion. A value of 0 disables the timeout. Minimum nonzero value is 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `m0_psel`, `m0_penable`, `m0_pwrite` input 1 each: master 0 APB controls.
- `m0_paddr` input PADDR_WL, `m0_pwdata` input PDATA_WL: master 0 address and write data.
- `m0_prdata` output PDATA_WL, `m0_pready` output 1, `m0_pslverr` output 1: master 0 response.
- `m1_*` input/output: identical set for master 1.
- `s_psel`, `s_penable`, `s_pwrite` output 1 each: slave-side APB controls.
- `s_paddr` output PADDR_WL, `s_pwdata` output PDATA_WL: slave-side address and write data.
- `s_prdata` input PDATA_WL, `s_pready` input 1, `s_pslverr` input 1: slave response.

## Operation

- Every master must honour `pready`. It holds `paddr`, `pwdata` and `pwrite` stable from SETUP until it samples `pready` high.
- States are IDLE, SETUP and ACCESS. State, `grant` and `last_grant` are registered.
- IDLE:
  - `req0` = `m0_psel`, `req1` = `m1_psel`.
  - With a single request, grant that master. With both requesting, grant the master that is not `last_grant`.
  - Any grant moves to SETUP. No request stays in IDLE.
- SETUP:
  - `s_psel`=1, `s_penable`=0.
  - Always moves to ACCESS the next cycle. The timeout counter is cleared.
- ACCESS:
  - `s_psel`=1, `s_penable`=1.
  - If `s_pready`=1: the transfer completes, `last_grant` <= `grant`, next state is IDLE.
  - Else if the counter equals TIMEOUT_CYCLES-1 (timeout enabled): forced completion, same transitions as a normal completion.
  - Otherwise the counter increments.
- `s_paddr`, `s_pwdata` and `s_pwrite` are combinational muxes of the granted master while `s_psel`=1, and 0 otherwise.
- Granted master response:
  - `mX_pready` = (ACCESS && (`s_pready` || timeout)).
  - `mX_prdata` = `s_prdata` when `mX_pready`=1, else 0.
  - `mX_pslverr` = `mX_pready` && (`s_pslverr` || timeout).
- Non-granted master: `pready`=0, `prdata`=0, `pslverr`=0. It stays stalled in its access phase until granted and completed.
- Counter width is clog2(TIMEOUT_CYCLES)+1. The counter saturates and never wraps.
- After reset, `last_grant`=1, so master 0 wins the first simultaneous request.

## Timing

- Reset values: all outputs 0, state IDLE, `grant`=0, counter 0.
- Reset asserted mid-transfer: returns to IDLE immediately. Master outputs drop to 0 and no completion is signalled.
- Request latency: `mX_psel` sampled high at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
- Zero-wait slave: the transfer completes in the ACCESS cycle, 3 cycles from request sample to `pready`.
- Each wait state extends ACCESS by one cycle.
- There is one IDLE cycle between consecutive slave transfers, so bus occupancy is a minimum of 3 cycles per transfer.
- Back-to-back requests alternate masters when both hold `psel` continuously.
- The timeout completes in the TIMEOUT_CYCLES-th ACCESS cycle. In that cycle `pready`=1 and `pslverr`=1, and `prdata` passes through whatever the slave drives.
- A late `s_pready` on the forced-completion cycle counts as a normal completion. `pslverr` still follows the timeout rule.
- A request arriving in SETUP or ACCESS is not sampled until the next IDLE cycle.

## Test plan

- **Single write, master 0:** drive `m0` write addr 0x12, data 0xA5, zero-wait slave. Require `s_psel` in cycle 1, `s_penable` in cycle 2 with `s_paddr`=0x12 and `s_pwdata`=0xA5, `m0_pready`=1 in cycle 2, `m1_pready`=0 throughout.
- **Simultaneous requests after reset:** `m0` reads 0x01, `m1` reads 0x02, slave returns 0x3C then 0xC3. Require m0 served first with `m0_prdata`=0x3C, one IDLE cycle, then m1 with `m1_prdata`=0xC3, and m1 `pready` low for 4 cycles first.
- **Round-robin fairness:** both masters hold `psel` for 6 transfers. Require grants m0, m1, m0, m1, m0, m1.
- **Wait states:** slave holds `s_pready`=0 for 3 ACCESS cycles. Require `m1_pready` only on the 4th ACCESS cycle, `s_paddr` stable meanwhile, `pslverr`=0.
- **Timeout:** TIMEOUT_CYCLES=4, slave never ready. Require `m0_pready`=1 and `m0_pslverr`=1 on the 4th ACCESS cycle, then IDLE. Repeat with TIMEOUT_CYCLES=0: ACCESS persists for 100 cycles.
- **Reset mid-ACCESS:** pulse `reset_b` low while in ACCESS. Require all outputs 0 asynchronously. After release, the next `m1` request completes normally with `m1` winning ties against `m0`? No: with `last_grant`=1, `m0` wins the first tie.
